gate_tester: RTL and testbench

GATE_TESTER -- requirements
Module: gate_tester

---
 rtl/gate_tester_if.sv | 23 ++
 rtl/gate_tester.sv | 125 ++++++++++++
 tb/tb_gate_tester.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/gate_tester_if.sv
// Bundles the control, stimulus and result signals between the tester and its environment.
// The master side is the tester itself; the slave side is the gate under test plus the controller.
interface gate_tester_if;
    logic       start;
    logic [2:0] sel;
    logic       A;
    logic       B;
    logic       F;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_mask;

    modport master (
        input  start, sel, F,
        output A, B, busy, done, pass, err_mask
    );

    modport slave (
        output start, sel, F,
        input  A, B, busy, done, pass, err_mask
    );
endinterface

// File: rtl/gate_tester.sv
// Applies the four A/B vectors to one selected gate, samples F SETTLE_CYCLES edges after each change.
// Latency: done rises 4*SETTLE_CYCLES cycles after start is accepted (1 cycle for an illegal sel); start ignored while busy.
module gate_tester #(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst,
    gate_tester_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t     state_q, state_d;
    logic [2:0] sel_q, sel_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] cnt_q, cnt_d;
    logic       a_q, a_d;
    logic       b_q, b_d;
    logic [3:0] err_q, err_d;
    logic       pass_q, pass_d;
    logic       exp_f;
    logic       mismatch;
    logic [3:0] err_nxt;
    logic [1:0] idx_inc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 3'd0;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            err_q   <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
        end
    end

    // F is sampled directly: the gate is combinational on our own registered A/B.
    always_comb begin
        exp_f = 1'b0;
        case (sel_q)
            3'd0:    exp_f = a_q & b_q;
            3'd1:    exp_f = a_q | b_q;
            3'd2:    exp_f = a_q ^ b_q;
            3'd3:    exp_f = ~a_q;
            3'd4:    exp_f = ~(a_q & b_q);
            default: exp_f = 1'b0;
        endcase
        mismatch       = bus.F ^ exp_f;
        err_nxt        = err_q;
        err_nxt[idx_q] = err_q[idx_q] | mismatch;
        idx_inc        = idx_q + 2'd1;
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        err_d   = err_q;
        pass_d  = pass_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    sel_d  = bus.sel;
                    idx_d  = 2'd0;
                    a_d    = 1'b0;
                    b_d    = 1'b0;
                    pass_d = 1'b0;
                    if (bus.sel <= 3'd4) begin
                        err_d   = 4'd0;
                        cnt_d   = CNT_LOAD;
                        state_d = SETTLE;
                    end else begin
                        err_d   = 4'hF;
                        state_d = DONE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    err_d = err_nxt;
                    if (idx_q != 2'd3) begin
                        idx_d = idx_inc;
                        a_d   = idx_inc[1];
                        b_d   = idx_inc[0];
                        cnt_d = CNT_LOAD;
                    end else begin
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                        pass_d  = (err_nxt == 4'd0);
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy = (state_q == SETTLE) || (state_q == DONE);
        bus.done = (state_q == DONE);
    end

    assign bus.A        = a_q;
    assign bus.B        = b_q;
    assign bus.pass     = pass_q;
    assign bus.err_mask = err_q;
endmodule

// File: tb/tb_gate_tester.sv
// Directed bench for gate_tester with SETTLE_CYCLES=2 and a behavioural gate model on F.
module tb_gate_tester;
    logic clk;
    logic rst;
    int   fmode;
    int   n_vec;
    int   n_err;
    int   n_done;

    gate_tester_if gif ();

    gate_tester #(.SETTLE_CYCLES(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (gif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Gate model: 0 AND, 1 NOT A, 2 tied low, 3 XOR
    always_comb begin
        case (fmode)
            0:       gif.F = gif.A & gif.B;
            1:       gif.F = ~gif.A;
            2:       gif.F = 1'b0;
            default: gif.F = gif.A ^ gif.B;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, "_ab"},   {6'd0, gif.A, gif.B}, 8'd0);
        chk({tag, "_busy"}, {7'd0, gif.busy}, 8'd0);
        chk({tag, "_done"}, {7'd0, gif.done}, 8'd0);
        chk({tag, "_pass"}, {7'd0, gif.pass}, 8'd0);
        chk({tag, "_err"},  {4'd0, gif.err_mask}, 8'd0);
    endtask

    // Runs one legal sequence, checking every cycle; sel is scrambled after acceptance.
    task automatic run_seq(input string tag, input logic [2:0] s, input int fm,
                           input logic [3:0] xerr, input logic xpass);
        logic [1:0] v;
        fmode = fm;
        @(negedge clk);
        gif.start = 1'b1;
        gif.sel   = s;
        @(negedge clk);
        gif.start = 1'b0;
        gif.sel   = ~s;
        for (int j = 0; j < 8; j++) begin
            v = 2'(j / 2);
            chk({tag, "_ab"},   {6'd0, gif.A, gif.B}, {6'd0, v});
            chk({tag, "_busy"}, {7'd0, gif.busy}, 8'd1);
            chk({tag, "_done"}, {7'd0, gif.done}, 8'd0);
            @(negedge clk);
        end
        chk({tag, "_done8"}, {7'd0, gif.done}, 8'd1);
        chk({tag, "_ab8"},   {6'd0, gif.A, gif.B}, 8'd0);
        chk({tag, "_err"},   {4'd0, gif.err_mask}, {4'd0, xerr});
        chk({tag, "_pass"},  {7'd0, gif.pass}, {7'd0, xpass});
        @(negedge clk);
        chk({tag, "_done9"}, {7'd0, gif.done}, 8'd0);
        chk({tag, "_busy9"}, {7'd0, gif.busy}, 8'd0);
        chk({tag, "_errh"},  {4'd0, gif.err_mask}, {4'd0, xerr});
        chk({tag, "_passh"}, {7'd0, gif.pass}, {7'd0, xpass});
    endtask

    initial begin
        n_vec     = 0;
        n_err     = 0;
        n_done    = 0;
        fmode     = 0;
        rst       = 1'b1;
        gif.start = 1'b0;
        gif.sel   = 3'd0;
        #1;
        chk_idle_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        run_seq("and_ok",   3'd0, 0, 4'b0000, 1'b1);
        run_seq("or_wrong", 3'd1, 0, 4'b0110, 1'b0);
        run_seq("not_ok",   3'd3, 1, 4'b0000, 1'b1);
        run_seq("not_zero", 3'd3, 2, 4'b0011, 1'b0);
        run_seq("nand_and", 3'd4, 0, 4'b1111, 1'b0);

        // Illegal select goes straight to DONE
        @(negedge clk);
        gif.start = 1'b1;
        gif.sel   = 3'd6;
        @(negedge clk);
        gif.start = 1'b0;
        chk("ill_done", {7'd0, gif.done}, 8'd1);
        chk("ill_err",  {4'd0, gif.err_mask}, 8'h0F);
        chk("ill_pass", {7'd0, gif.pass}, 8'd0);
        chk("ill_ab",   {6'd0, gif.A, gif.B}, 8'd0);
        @(negedge clk);
        chk("ill_done1", {7'd0, gif.done}, 8'd0);
        chk("ill_busy1", {7'd0, gif.busy}, 8'd0);
        chk("ill_ab1",   {6'd0, gif.A, gif.B}, 8'd0);
        chk("ill_errh",  {4'd0, gif.err_mask}, 8'h0F);

        // Reset mid-sequence at idx=2 (vector 1 already mismatched)
        fmode = 0;
        @(negedge clk);
        gif.start = 1'b1;
        gif.sel   = 3'd1;
        @(negedge clk);
        gif.start = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_ab",  {6'd0, gif.A, gif.B}, 8'd2);
        chk("pre_rst_err", {4'd0, gif.err_mask}, 8'h02);
        #2;
        rst = 1'b1;
        #1;
        chk_idle_zero("async_rst");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("rst_nodone", {7'd0, gif.done}, 8'd0);
        end
        rst = 1'b0;
        run_seq("xor_after_rst", 3'd2, 3, 4'b0000, 1'b1);

        // Start held high: back-to-back runs with one idle cycle between them
        fmode = 3;
        @(negedge clk);
        gif.start = 1'b1;
        gif.sel   = 3'd2;
        @(negedge clk);
        for (int j = 0; j < 30; j++) begin
            chk("held_busy", {7'd0, gif.busy}, {7'd0, (j % 10) != 9});
            chk("held_done", {7'd0, gif.done}, {7'd0, (j % 10) == 8});
            if (gif.done) n_done++;
            @(negedge clk);
        end
        gif.start = 1'b0;
        chk("held_npulse", 8'(n_done), 8'd3);
        repeat (10) @(negedge clk);
        chk("held_pass", {7'd0, gif.pass}, 8'd1);
        chk("held_idle", {7'd0, gif.busy}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
